// File: rtl/inst_boot_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> 32-bit instruction-memory writes; core held off until DONE.
// Write latency 1 cycle after the 4th byte; no stall on writes. Optional trailing XOR byte under INST_LOADER_CHECKSUM_EN.
module inst_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              core_enable
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR, S_CHK} state_t;
    localparam state_t S_TAIL = S_CHK;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR} state_t;
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            state, state_nxt;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        lane;
    logic [23:0]       word_buf;
    logic              xfer;
    logic              start_ok;
    logic              last_byte;
    logic [15:0]       len_in;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]        chk_acc;
`endif

    assign len_in    = {in_data, len_lo};
    assign xfer      = in_valid & in_ready;
    assign last_byte = (lane == 2'd3) && ((32'(word_idx) + 32'd1) == 32'(len));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        core_enable = 1'b0;
        start_ok    = 1'b0;
        case (state)
            S_IDLE: start_ok = start;
            S_LEN0: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = S_LEN1;
            end
            S_LEN1: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (len_in == 16'd0)                state_nxt = S_TAIL;
                    else if (32'(len_in) > MAX_WORDS)   state_nxt = S_ERR;
                    else                                state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // Leave on the handshake of the final byte; its write issues in the first tail cycle.
                if (in_valid && last_byte) state_nxt = S_TAIL;
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = (in_data == chk_acc) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                done        = 1'b1;
                core_enable = 1'b1;
                start_ok    = start;
            end
            S_ERR: begin
                err      = 1'b1;
                start_ok = start;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (start_ok) state_nxt = S_LEN0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo    <= '0;
            len       <= '0;
            word_idx  <= '0;
            lane      <= '0;
            word_buf  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            chk_acc   <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                word_idx <= '0;
                lane     <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                chk_acc  <= '0;
`endif
            end
            if (xfer) begin
                case (state)
                    S_LEN0: len_lo <= in_data;
                    S_LEN1: len    <= len_in;
                    S_DATA: begin
                        lane <= lane + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                        chk_acc <= chk_acc ^ in_data;
`endif
                        if (lane == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx[ADDR_W-1:0];
                            mem_wdata <= {in_data, word_buf};
                            word_idx  <= word_idx + 1'b1;
                        end else begin
                            word_buf[{lane, 3'b000} +: 8] <= in_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
